// File: rtl/packet_encoder.sv
// Transmit-side framer: snapshots btn/x/y on a send request and feeds the frame
// AA AA 07 03 btn x y sum to uart_tx one byte per tx_start, with a per-byte tx_done timeout.
module packet_encoder #(
    parameter logic [7:0] HEAD0   = 8'hAA,
    parameter logic [7:0] HEAD1   = 8'hAA,
    parameter logic [7:0] LEN     = 8'h07,
    parameter logic [7:0] CMD     = 8'h03,
    parameter int         TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [7:0] btn_in,
    input  logic [7:0] x_in,
    input  logic [7:0] y_in,
    input  logic       tx_done,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SEND  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ABORT = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [1:0]    hist_q, hist_d;
    logic [7:0]    btn_q, x_q, y_q;
    logic          accept;
    logic          dflag;

    function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [7:0] b,
                                              input logic [7:0] x, input logic [7:0] y,
                                              input logic [7:0] s);
        logic [7:0] r;
        case (i)
            3'd0:    r = HEAD0;
            3'd1:    r = HEAD1;
            3'd2:    r = LEN;
            3'd3:    r = CMD;
            3'd4:    r = b;
            3'd5:    r = x;
            3'd6:    r = y;
            default: r = s;
        endcase
        return r;
    endfunction

    // {prev,cur} of tx_done; only a 0->1 transition counts, so a held level cannot re-trigger
    assign hist_d = {hist_q[0], tx_done};
    assign dflag  = (hist_q == 2'b01);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            sum_q     <= '0;
            timer_q   <= '0;
            tx_data_q <= '0;
            hist_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            timer_q   <= timer_d;
            tx_data_q <= tx_data_d;
            hist_q    <= hist_d;
        end
    end

    // Payload snapshot; only meaningful after an accepted send, so no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            btn_q <= btn_in;
            x_q   <= x_in;
            y_q   <= y_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        timer_d   = timer_q;
        tx_data_d = tx_data_q;
        accept    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (send) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                tx_data_d = frame_byte(idx_q, btn_q, x_q, y_q, sum_q);
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (idx_q != 3'd7) begin
                    sum_d = csum_add(sum_q, tx_data_q);
                end
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                // A completion in the last timeout cycle still counts
                if (dflag) begin
                    if (idx_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_LOAD;
                    end
                end else if (timer_q == TLAST) begin
                    state_d = S_ABORT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_start = (state_q == S_SEND);
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        err      = (state_q == S_ABORT);
        tx_data  = tx_data_q;
    end

    // Handshake invariants relied on by uart_tx and the game logic
    a_done_err_excl : assert property (@(posedge clk) disable iff (!rst_n) !(done && err));
    a_start_no_end  : assert property (@(posedge clk) disable iff (!rst_n) !(tx_start && (done || err)));
    a_data_stable   : assert property (@(posedge clk) disable iff (!rst_n)
                                       tx_start |=> $stable(tx_data));

endmodule

// File: tb/tb_packet_encoder.sv
// Bench for packet_encoder: a time-stamped event model predicts every output each cycle.
module tb_packet_encoder;

    localparam int T       = 50;
    localparam int M_PULSE = 0;
    localparam int M_STALL = 1;
    localparam int M_LEVEL = 2;
    localparam int M_RAND  = 3;

    logic       clk = 1'b0;
    logic       rst_n, send, tx_done;
    logic [7:0] btn_in, x_in, y_in, tx_data;
    logic       tx_start, busy, done, err;

    packet_encoder #(.TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .send(send),
        .btn_in(btn_in), .x_in(x_in), .y_in(y_in),
        .tx_done(tx_done), .tx_data(tx_data), .tx_start(tx_start),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;
    int td_mode  = M_PULSE;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: frame contents from plain arithmetic, event times from the handshake rules
    // (first tx_start 2 cycles after acceptance; a tx_done rise sampled at edge e inside the
    // wait window [s+1, s+T] gives the next tx_start at e+2 or done at e+1; else err at s+T+1).
    logic         m_active = 1'b0;
    logic [7:0]   m_frame [8];
    int           m_idx = 0;
    longint       m_s = -1, m_data_cyc = -1, m_done_cyc = -1, m_err_cyc = -1;
    logic [7:0]   m_data_val = 8'h00, m_data = 8'h00;
    logic         m_waiting = 1'b0, m_prev_td = 1'b0;

    task automatic schedule(input longint load_cyc);
        m_s        = load_cyc + 1;
        m_data_cyc = m_s;
        m_data_val = m_frame[m_idx];
        m_waiting  = 1'b1;
        m_err_cyc  = m_s + T + 1;
    endtask

    always @(negedge clk) begin
        logic   exp_start, exp_done, exp_err, rise;
        longint e;
        int     s;
        if (!rst_n) begin
            chk("reset_outputs", 32'({tx_data, tx_start, busy, done, err}), 32'd0);
            m_active  = 1'b0; m_prev_td = 1'b0; m_data = 8'h00; m_waiting = 1'b0;
            m_s = -1; m_data_cyc = -1; m_done_cyc = -1; m_err_cyc = -1;
        end else begin
            if (cyc == m_data_cyc) m_data = m_data_val;
            exp_start = m_active && (cyc == m_s);
            exp_done  = (cyc == m_done_cyc);
            exp_err   = (cyc == m_err_cyc);
            chk("tx_start", 32'(tx_start), 32'(exp_start));
            chk("done",     32'(done),     32'(exp_done));
            chk("err",      32'(err),      32'(exp_err));
            chk("busy",     32'(busy),     32'(m_active));
            chk("tx_data",  32'(tx_data),  32'(m_data));
            e    = cyc + 1;
            rise = tx_done && !m_prev_td;
            m_prev_td = tx_done;
            if (m_active && m_waiting && rise && e >= m_s + 1 && e <= m_s + T) begin
                m_waiting = 1'b0;
                m_err_cyc = -1;
                if (m_idx == 7) m_done_cyc = e + 1;
                else begin
                    m_idx++;
                    schedule(e + 1);
                end
            end
            if (cyc == m_done_cyc || cyc == m_err_cyc) begin
                m_active = 1'b0;
            end else if (!m_active && send) begin
                s = 'hAA + 'hAA + 'h07 + 'h03 + int'(btn_in) + int'(x_in) + int'(y_in);
                m_frame[0] = 8'hAA; m_frame[1] = 8'hAA; m_frame[2] = 8'h07; m_frame[3] = 8'h03;
                m_frame[4] = btn_in; m_frame[5] = x_in; m_frame[6] = y_in; m_frame[7] = 8'(s % 256);
                m_idx    = 0;
                m_active = 1'b1;
                schedule(cyc + 1);
            end
        end
    end

    logic [7:0] col_bytes [$];
    longint     col_cyc [$];
    int         done_cnt = 0, err_cnt = 0;
    longint     last_err_cyc = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_start) begin
                col_bytes.push_back(tx_data);
                col_cyc.push_back(cyc);
            end
            if (done) done_cnt++;
            if (err) begin
                err_cnt++;
                last_err_cyc = cyc;
            end
        end
    end

    // uart_tx stand-in: answers each tx_start according to td_mode
    initial begin
        int   cnt, hold, w, nb, lcnt;
        logic lvl;
        cnt = 0; hold = 0; w = 1; nb = 0; lcnt = 0; lvl = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                cnt = 0; hold = 0; lcnt = 0; nb = 0; tx_done = 1'b0;
            end else begin
                if (!busy) nb = 0;
                if (tx_start) begin
                    w = 1;
                    case (td_mode)
                        M_PULSE: cnt = 11;
                        M_STALL: begin
                            if (nb < 3) cnt = 11;
                            nb++;
                        end
                        M_LEVEL: lcnt = 6;
                        default: begin
                            if ($urandom_range(0, 15) != 0) begin
                                cnt = $urandom_range(0, 12) + 1;
                                w   = $urandom_range(1, 3);
                            end
                        end
                    endcase
                end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) hold = w;
                end
                if (lcnt > 0) begin
                    lcnt--;
                    if (lcnt == 3) lvl = 1'b0;
                    else if (lcnt == 0) lvl = 1'b1;
                end
                if (td_mode == M_LEVEL) tx_done = lvl;
                else begin
                    tx_done = (hold > 0);
                    if (hold > 0) hold--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_col();
        col_bytes.delete();
        col_cyc.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic [7:0] x, input logic [7:0] y);
        btn_in = b; x_in = x; y_in = y; send = 1'b1;
        tick();
        send = 1'b0;
        btn_in = 8'($urandom); x_in = 8'($urandom); y_in = 8'($urandom);
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int n = 0;
        while (m_active && n < maxc) begin
            tick();
            n++;
        end
        chk({tag, "_finished"}, 32'(m_active), 32'd0);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic check_frame(input string tag, input logic [63:0] exp);
        logic [7:0] eb;
        chk({tag, "_nbytes"}, 32'(col_bytes.size()), 32'd8);
        for (int i = 0; i < 8 && i < col_bytes.size(); i++) begin
            eb = exp[63 - 8 * i -: 8];
            chk($sformatf("%s_byte%0d", tag, i), 32'(col_bytes[i]), 32'(eb));
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; send = 1'b0; btn_in = 8'h00; x_in = 8'h00; y_in = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // basic frame, 1-cycle tx_done 10 cycles after each tx_start
        clear_col(); td_mode = M_PULSE;
        send_frame(8'h01, 8'h07, 8'h09);
        wait_idle(2000, "t1");
        check_frame("t1", 64'hAAAA_0703_0107_096F);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_err_cnt", 32'(err_cnt), 32'd0);

        // checksum wraps modulo 256
        tick(); clear_col();
        send_frame(8'hFF, 8'hFF, 8'hFF);
        wait_idle(2000, "t2");
        check_frame("t2", 64'hAAAA_0703_FFFF_FF5B);

        // send held high: frames start only from IDLE, three fit in 250 cycles
        tick(); clear_col();
        send = 1'b1;
        repeat (250) begin
            tick();
            btn_in = 8'($urandom); x_in = 8'($urandom); y_in = 8'($urandom);
        end
        send = 1'b0;
        wait_idle(2000, "t3a");
        chk("t3a_done_cnt", 32'(done_cnt), 32'd3);
        chk("t3a_starts", 32'(col_bytes.size()), 32'd24);

        // extra send pulses while busy are dropped
        tick(); clear_col();
        send_frame(8'h12, 8'h34, 8'h56);
        for (int k = 0; k < 3; k++) begin
            repeat (25) tick();
            send = 1'b1;
            tick();
            send = 1'b0;
        end
        wait_idle(2000, "t3b");
        check_frame("t3b", 64'hAAAA_0703_1234_56FA);
        chk("t3b_done_cnt", 32'(done_cnt), 32'd1);

        // no tx_done for the 4th byte: abort after T wait cycles
        tick(); clear_col(); td_mode = M_STALL;
        send_frame(8'h11, 8'h22, 8'h33);
        wait_idle(1000, "t4");
        chk("t4_err_cnt", 32'(err_cnt), 32'd1);
        chk("t4_done_cnt", 32'(done_cnt), 32'd0);
        chk("t4_starts", 32'(col_bytes.size()), 32'd4);
        if (col_bytes.size() >= 4) begin
            chk("t4_byte3", 32'(col_bytes[3]), 32'h03);
            chk("t4_err_delay", 32'(last_err_cyc - col_cyc[3]), 32'(T + 1));
        end
        tick(); clear_col(); td_mode = M_PULSE;
        send_frame(8'h05, 8'h06, 8'h07);
        wait_idle(2000, "t4r");
        check_frame("t4r", 64'hAAAA_0703_0506_0770);

        // asynchronous reset in the middle of the frame
        tick(); clear_col();
        send_frame(8'h21, 8'h43, 8'h65);
        n = 0;
        while (col_bytes.size() < 5 && n < 500) begin
            tick();
            n++;
        end
        chk("t5_reached_byte5", 32'(col_bytes.size() >= 5), 32'd1);
        repeat (3) tick();
        #1 rst_n = 1'b0;
        #1 chk("t5_async_zero", 32'({tx_data, tx_start, busy, done, err}), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        clear_col();
        send_frame(8'h0F, 8'hF0, 8'h55);
        wait_idle(2000, "t5");
        check_frame("t5", 64'hAAAA_0703_0FF0_55B2);
        chk("t5_done_cnt", 32'(done_cnt), 32'd1);

        // tx_done held as a level across the next LOAD/SEND
        tick(); clear_col(); td_mode = M_LEVEL;
        send_frame(8'h80, 8'h01, 8'h7F);
        wait_idle(2000, "t6");
        check_frame("t6", 64'hAAAA_0703_8001_7F5E);
        chk("t6_done_cnt", 32'(done_cnt), 32'd1);
        chk("t6_err_cnt", 32'(err_cnt), 32'd0);

        // randomized traffic: random delays/widths, occasional stalls, stray sends, one reset
        td_mode = M_RAND;
        for (int f = 0; f < 25; f++) begin
            repeat ($urandom_range(0, 4)) tick();
            send_frame(8'($urandom), 8'($urandom), 8'($urandom));
            if (f == 12) begin
                repeat ($urandom_range(5, 60)) tick();
                #1 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            n = 0;
            while (m_active && n < 3000) begin
                tick();
                send   = ($urandom_range(0, 9) == 0);
                btn_in = 8'($urandom); x_in = 8'($urandom); y_in = 8'($urandom);
                n++;
            end
            send = 1'b0;
            wait_idle(1000, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
